// File: rtl/ula_dec.sv
// -----------------------------------------------------------------------------
// ula_dec : 32-bit combinational ALU with a MIPS-style ALU-control decoder and
// a registered status stage (result, zero, signed overflow).
//
// Ports:
//   funct    [5:0]  in   instruction funct field, decoded when aluop = 2'b10
//   aluop    [1:0]  in   operation class from main control
//   a        [31:0] in   operand A (rs)
//   b        [31:0] in   operand B (rt or immediate)
//   saida1   [31:0] out  combinational ALU result
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset (registered outputs only)
//   zero            out  combinational, 1 when saida1 == 0
//   saida1_q [31:0] out  saida1 registered one cycle later
//   zero_q          out  zero registered one cycle later
//   ovf_q           out  signed-overflow flag registered one cycle later
//
// Build option:
//   ULA_EXT_OPS_EN  when defined, adds xor, nor, sltu, sll, srl and sra to the
//                   funct decode; otherwise those codes yield a zero result.
// -----------------------------------------------------------------------------
module ula_dec (
    input  logic [5:0]  funct,
    input  logic [1:0]  aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] saida1,
    input  logic        clk,
    input  logic        reset,
    output logic        zero,
    output logic [31:0] saida1_q,
    output logic        zero_q,
    output logic        ovf_q
);

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
`ifdef ULA_EXT_OPS_EN
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
`endif

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_SLT  = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOR  = 4'd7,
        OP_SLTU = 4'd8,
        OP_SLL  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SRA  = 4'd11
    } op_e;

    op_e         op_s;
    logic        chk_ovf_s;   // only signed add/sub may report overflow
    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic        ovf_add_s;
    logic        ovf_sub_s;
    logic        ovf_s;
    logic [31:0] result_s;

    // ALU-control decode: aluop class plus funct field to an operation
    always_comb begin
        op_s      = OP_NONE;
        chk_ovf_s = 1'b0;
        case (aluop)
            2'b00: begin
                op_s      = OP_ADD;
                chk_ovf_s = 1'b1;
            end
            2'b01: begin
                op_s      = OP_SUB;
                chk_ovf_s = 1'b1;
            end
            2'b11: begin
                op_s      = OP_OR;
                chk_ovf_s = 1'b0;
            end
            2'b10: begin
                case (funct)
                    F_ADD:  begin op_s = OP_ADD; chk_ovf_s = 1'b1; end
                    F_ADDU: op_s = OP_ADD;
                    F_SUB:  begin op_s = OP_SUB; chk_ovf_s = 1'b1; end
                    F_SUBU: op_s = OP_SUB;
                    F_AND:  op_s = OP_AND;
                    F_OR:   op_s = OP_OR;
                    F_SLT:  op_s = OP_SLT;
`ifdef ULA_EXT_OPS_EN
                    F_XOR:  op_s = OP_XOR;
                    F_NOR:  op_s = OP_NOR;
                    F_SLTU: op_s = OP_SLTU;
                    F_SLL:  op_s = OP_SLL;
                    F_SRL:  op_s = OP_SRL;
                    F_SRA:  op_s = OP_SRA;
`endif
                    default: op_s = OP_NONE;
                endcase
            end
            default: op_s = OP_NONE;
        endcase
    end

    assign sum_s  = a + b;   // modulo 2^32, carry out discarded
    assign diff_s = a - b;

    // Overflow from operand/result signs; slt does not depend on these
    assign ovf_add_s = (a[31] == b[31]) && (sum_s[31]  != a[31]);
    assign ovf_sub_s = (a[31] != b[31]) && (diff_s[31] != a[31]);

    // Result mux and overflow select
    always_comb begin
        result_s = 32'd0;
        ovf_s    = 1'b0;
        case (op_s)
            OP_ADD: begin
                result_s = sum_s;
                ovf_s    = chk_ovf_s & ovf_add_s;
            end
            OP_SUB: begin
                result_s = diff_s;
                ovf_s    = chk_ovf_s & ovf_sub_s;
            end
            OP_AND:  result_s = a & b;
            OP_OR:   result_s = a | b;
            // Signed compare so the answer stays right when a - b overflows
            OP_SLT:  result_s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_XOR:  result_s = a ^ b;
            OP_NOR:  result_s = ~(a | b);
            OP_SLTU: result_s = (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  result_s = b << a[4:0];
            OP_SRL:  result_s = b >> a[4:0];
            OP_SRA:  result_s = $unsigned($signed(b) >>> a[4:0]);
            default: begin
                result_s = 32'd0;
                ovf_s    = 1'b0;
            end
        endcase
    end

    assign saida1 = result_s;
    assign zero   = (result_s == 32'd0);

    logic [31:0] saida1_d;
    logic        zero_d;
    logic        ovf_d;
    logic [31:0] saida1_r_q;
    logic        zero_r_q;
    logic        ovf_r_q;

    assign saida1_d = result_s;
    assign zero_d   = zero;
    assign ovf_d    = ovf_s;

    // Status stage: captures result, zero and overflow every edge
    always_ff @(posedge clk) begin
        if (reset) begin
            saida1_r_q <= 32'd0;
            zero_r_q   <= 1'b0;
            ovf_r_q    <= 1'b0;
        end else begin
            saida1_r_q <= saida1_d;
            zero_r_q   <= zero_d;
            ovf_r_q    <= ovf_d;
        end
    end

    assign saida1_q = saida1_r_q;
    assign zero_q   = zero_r_q;
    assign ovf_q    = ovf_r_q;

endmodule

// File: tb/tb_ula_dec.sv
module tb_ula_dec;

    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] saida1;
    logic        clk;
    logic        reset;
    logic        zero;
    logic [31:0] saida1_q;
    logic        zero_q;
    logic        ovf_q;

    int errors = 0;
    int checks = 0;

    ula_dec dut (
        .funct    (funct),
        .aluop    (aluop),
        .a        (a),
        .b        (b),
        .saida1   (saida1),
        .clk      (clk),
        .reset    (reset),
        .zero     (zero),
        .saida1_q (saida1_q),
        .zero_q   (zero_q),
        .ovf_q    (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{"add_5_7",      2'b00, 6'b000000, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{"sub_eq",       2'b01, 6'b000000, 32'h0000_1234,  32'h0000_1234,  32'd0,          1'b0};
        vecs[2]  = '{"sub_3_5",      2'b01, 6'b000000, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
        vecs[3]  = '{"and",          2'b10, 6'b100100, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0};
        vecs[4]  = '{"or",           2'b10, 6'b100101, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFFF0_FFF0,  1'b0};
        vecs[5]  = '{"slt_neg1_1",   2'b10, 6'b101010, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
        vecs[6]  = '{"slt_max_min",  2'b10, 6'b101010, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[7]  = '{"slt_subovf",   2'b10, 6'b101010, 32'h8000_0000,  32'd1,          32'd1,          1'b0};
        vecs[8]  = '{"add_ovf",      2'b00, 6'b000000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1};
        vecs[9]  = '{"addu_noovf",   2'b10, 6'b100001, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0};
        vecs[10] = '{"fadd_ovf",     2'b10, 6'b100000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1};
        vecs[11] = '{"sub_ovf",      2'b01, 6'b000000, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1};
        vecs[12] = '{"subu_noovf",   2'b10, 6'b100011, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0};
        vecs[13] = '{"ori",          2'b11, 6'b000000, 32'h00FF_0000,  32'h0000_FF00,  32'h00FF_FF00,  1'b0};
        vecs[14] = '{"add_carry",    2'b00, 6'b000000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[15] = '{"undef_funct",  2'b10, 6'b111111, 32'h1234_5678,  32'h0000_0001,  32'd0,          1'b0};
`ifdef ULA_EXT_OPS_EN
        vecs[16] = '{"xor",          2'b10, 6'b100110, 32'h0F0F_0F0F,  32'hFFFF_0000,  32'hF0F0_0F0F,  1'b0};
        vecs[17] = '{"nor",          2'b10, 6'b100111, 32'h0000_0000,  32'h0000_00FF,  32'hFFFF_FF00,  1'b0};
        vecs[18] = '{"sltu",         2'b10, 6'b101011, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0};
        vecs[19] = '{"sll",          2'b10, 6'b000000, 32'd4,          32'd1,          32'd16,         1'b0};
        vecs[20] = '{"sra",          2'b10, 6'b000011, 32'd4,          32'h8000_0000,  32'hF800_0000,  1'b0};
`else
        vecs[16] = '{"xor_off",      2'b10, 6'b100110, 32'h0F0F_0F0F,  32'hFFFF_0000,  32'd0,          1'b0};
        vecs[17] = '{"nor_off",      2'b10, 6'b100111, 32'h0000_0000,  32'h0000_00FF,  32'd0,          1'b0};
        vecs[18] = '{"sltu_off",     2'b10, 6'b101011, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[19] = '{"sll_off",      2'b10, 6'b000000, 32'd4,          32'd1,          32'd0,          1'b0};
        vecs[20] = '{"sra_off",      2'b10, 6'b000011, 32'd4,          32'h8000_0000,  32'd0,          1'b0};
`endif

        // Reset with nonzero operands: registers held clear, saida1 still live
        reset = 1'b1;
        aluop = 2'b00;
        funct = 6'b000000;
        a     = 32'd5;
        b     = 32'd7;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("rst_saida1_q", saida1_q, 32'd0);
            chk("rst_zero_q",   {31'd0, zero_q}, 32'd0);
            chk("rst_ovf_q",    {31'd0, ovf_q},  32'd0);
            chk("rst_saida1",   saida1, 32'd12);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_saida1_q", saida1_q, 32'd12);

        // Table-driven vectors: combinational check, then registered check
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            aluop = vecs[i].aluop;
            funct = vecs[i].funct;
            a     = vecs[i].a;
            b     = vecs[i].b;
            #1;
            chk({vecs[i].name, "/saida1"}, saida1, vecs[i].res);
            chk({vecs[i].name, "/zero"}, {31'd0, zero}, {31'd0, (vecs[i].res == 32'd0)});
            @(posedge clk);
            #1;
            chk({vecs[i].name, "/saida1_q"}, saida1_q, vecs[i].res);
            chk({vecs[i].name, "/zero_q"}, {31'd0, zero_q}, {31'd0, (vecs[i].res == 32'd0)});
            chk({vecs[i].name, "/ovf_q"}, {31'd0, ovf_q}, {31'd0, vecs[i].ovf});
        end

        // Mid-stream reset while an overflowing add is present
        @(negedge clk);
        aluop = 2'b00;
        funct = 6'b000000;
        a     = 32'h7FFF_FFFF;
        b     = 32'd1;
        @(posedge clk);
        #1;
        chk("mid_pre_ovf_q", {31'd0, ovf_q}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ovf_q",    {31'd0, ovf_q}, 32'd0);
        chk("mid_rst_saida1_q", saida1_q, 32'd0);
        chk("mid_rst_saida1",   saida1, 32'h8000_0000);
        @(negedge clk);
        reset = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        @(posedge clk);
        #1;
        chk("mid_post_zero_q",   {31'd0, zero_q}, 32'd1);
        chk("mid_post_saida1_q", saida1_q, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
